matrix_write_arbiter: RTL and testbench
=======================================

MATRIX_WRITE_ARBITER -- requirements
Module: matrix_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, matrix element width.
REQ-002 Parameter MAX_ELEMS, 1150, largest legal rows*cols (slot of 1152 words minus 2 header words).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rq_request  in  2  per-requester level request; bit0 = input parser, bit1 = compute result.
REQ-006 rq_matrix_id  in  2x3  target matrix slot per requester.
REQ-007 rq_rows, rq_cols  in  2x8 each  matrix dimensions per requester.
REQ-008 rq_data  in  2xDATA_WIDTH  element stream per requester.
REQ-009 rq_data_valid  in  2  element strobe per requester.
REQ-010 rq_grant  out  2  one-hot, high while that requester owns the writer.
REQ-011 rq_done  out  2  one-cycle completion pulse to owner.
REQ-012 rq_error  out  2  one-cycle pulse, coincident with rq_done, on reject or underrun.
REQ-013 write_request  out  1  request to shared matrix writer.
REQ-014 write_ready  in  1  writer can accept a transaction.
REQ-015 write_matrix_id / write_rows / write_cols  out  3/8/8  latched header of granted transfer.
REQ-016 write_data  out  DATA_WIDTH  forwarded element.
REQ-017 write_data_valid  out  1  forwarded element strobe.
REQ-018 write_done  in  1  writer completion pulse.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 overflow  out  1  one-cycle pulse per dropped excess beat.

Function
REQ-021 FSM states: IDLE, CHECK, REQ, STREAM, FINISH.
REQ-022 IDLE: a request is sampled; if both bits are set, grant goes to the requester that is not last_owner; the winner's id/rows/cols are latched; go to CHECK.
REQ-023 CHECK: expected = rows*cols (16-bit product); if expected is 0 or > MAX_ELEMS, go to FINISH with reject flag set and no write_request; otherwise go to REQ.
REQ-024 rq_grant[owner] asserts on entry to CHECK and deasserts on entry to IDLE.
REQ-025 REQ: write_request = 1; on a cycle where write_request && write_ready, go to STREAM; write_request drops to 0 on STREAM entry.
REQ-026 STREAM: write_data/write_data_valid are registered copies of rq_data/rq_data_valid of owner (1-cycle latency); the non-owner's stream is ignored.
REQ-027 Beat counter: increments per forwarded beat; a beat arriving when count == expected is not forwarded and pulses overflow.
REQ-028 STREAM: on write_done go to FINISH; underrun flag set if count < expected at that cycle.
REQ-029 write_done in IDLE, CHECK or REQ is ignored.
REQ-030 FINISH (1 cycle): rq_done[owner] = 1; rq_error[owner] = reject | underrun; last_owner <= owner; next state IDLE.
REQ-031 rq_request deassertion after grant has no effect; a request still high in IDLE after FINISH is re-arbitrated normally.
REQ-032 Header outputs hold the latched values from CHECK until next grant.

Reset
REQ-033 rst: state IDLE, last_owner = 1 (requester 0 wins first tie), counter 0, header regs 0.
REQ-034 rst: write_request, write_data_valid, write_data, rq_grant, rq_done, rq_error, busy, overflow all 0.
REQ-035 rst mid-transfer aborts silently; the writer is not notified and no rq_done is issued.

Verification
REQ-036 Req0 alone, 2x2, id 1, write_ready=1, 4 beats, write_done 50 cycles later -> write_request 1 cycle, write_matrix_id=1, 4 write_data_valid beats 1 cycle delayed, rq_done[0] pulse, rq_error[0]=0.
REQ-037 Req0 and req1 both high after reset -> requester 0 granted first; after its FINISH requester 1 granted; next simultaneous pair -> requester 0 again (alternation).
REQ-038 Req1 with rows=0 or 40x40 -> no write_request; rq_done[1] and rq_error[1] pulse 2 cycles after sampling; busy returns 0.
REQ-039 2x2 transfer with 6 beats -> exactly 4 forwarded, overflow pulses twice; write_done after 3 beats in a separate run -> rq_error pulses (underrun).
REQ-040 write_ready held 0 for 20 cycles -> write_request held high 20 cycles, no data forwarded; non-owner rq_data_valid during STREAM never appears on write_data_valid.
REQ-041 rst asserted in STREAM -> next cycle all outputs 0, state IDLE, no rq_done.

Source files
------------

// File: rtl/matrix_write_arbiter.sv
// Two-requester front end for the shared matrix writer. Ties alternate between requesters,
// headers are checked against slot capacity, and element beats are forwarded with overflow/underrun reporting.
module matrix_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ELEMS  = 1150
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              rq_request,
  input  logic [5:0]              rq_matrix_id,
  input  logic [15:0]             rq_rows,
  input  logic [15:0]             rq_cols,
  input  logic [2*DATA_WIDTH-1:0] rq_data,
  input  logic [1:0]              rq_data_valid,
  output logic [1:0]              rq_grant,
  output logic [1:0]              rq_done,
  output logic [1:0]              rq_error,
  output logic                    write_request,
  input  logic                    write_ready,
  output logic [2:0]              write_matrix_id,
  output logic [7:0]              write_rows,
  output logic [7:0]              write_cols,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    write_data_valid,
  input  logic                    write_done,
  output logic                    busy,
  output logic                    overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_STREAM,
    S_FINISH
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_ELEMS);

  // Per-requester views of the packed request buses
  logic [2:0]            req_id    [2];
  logic [7:0]            req_rows  [2];
  logic [7:0]            req_cols  [2];
  logic [DATA_WIDTH-1:0] req_data  [2];
  logic                  req_valid [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign req_id[gi]    = rq_matrix_id[gi*3 +: 3];
    assign req_rows[gi]  = rq_rows[gi*8 +: 8];
    assign req_cols[gi]  = rq_cols[gi*8 +: 8];
    assign req_data[gi]  = rq_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_valid[gi] = rq_data_valid[gi];
  end

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [2:0]            id_q, id_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic [15:0]           expected_q, expected_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            error_q, error_d;
  logic                  wreq_q, wreq_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic                  winner;
  logic [15:0]           product;

  // A lone request wins outright; a tie goes to whoever did not own the writer last
  always_comb begin
    winner = rq_request[1];
    if (&rq_request) begin
      winner = ~last_owner_q;
    end
  end

  assign product = {8'd0, rows_q} * {8'd0, cols_q};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    id_d         = id_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    expected_d   = expected_q;
    count_d      = count_q;
    grant_d      = grant_q;
    done_d       = 2'b00;
    error_d      = 2'b00;
    wreq_d       = wreq_q;
    wdata_d      = wdata_q;
    wvalid_d     = 1'b0;
    overflow_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|rq_request) begin
          owner_d = winner;
          id_d    = req_id[winner];
          rows_d  = req_rows[winner];
          cols_d  = req_cols[winner];
          count_d = 16'd0;
          grant_d = winner ? 2'b10 : 2'b01;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        expected_d = product;
        if (product == 16'd0 || product > MAX_W) begin
          done_d[owner_q]  = 1'b1;
          error_d[owner_q] = 1'b1;
          state_d          = S_FINISH;
        end else begin
          wreq_d  = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (write_ready) begin
          wreq_d  = 1'b0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (req_valid[owner_q]) begin
          if (count_q == expected_q) begin
            overflow_d = 1'b1;
          end else begin
            wvalid_d = 1'b1;
            wdata_d  = req_data[owner_q];
            count_d  = count_q + 16'd1;
          end
        end
        // Only underrun can flag an error here; rejected headers never reach STREAM
        if (write_done) begin
          done_d[owner_q]  = 1'b1;
          error_d[owner_q] = (count_q < expected_q);
          state_d          = S_FINISH;
        end
      end

      S_FINISH: begin
        grant_d      = 2'b00;
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        wreq_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      id_q         <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      expected_q   <= '0;
      count_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      error_q      <= '0;
      wreq_q       <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      id_q         <= id_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      expected_q   <= expected_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      error_q      <= error_d;
      wreq_q       <= wreq_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rq_grant         = grant_q;
  assign rq_done          = done_q;
  assign rq_error         = error_q;
  assign write_request    = wreq_q;
  assign write_matrix_id  = id_q;
  assign write_rows       = rows_q;
  assign write_cols       = cols_q;
  assign write_data       = wdata_q;
  assign write_data_valid = wvalid_q;
  assign busy             = busy_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Randomized scoreboard bench for matrix_write_arbiter: the driver predicts owners, headers,
// forwarded beats and completion status; a negedge monitor pops and compares.
module tb_matrix_write_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rq_request;
  logic [5:0]      rq_matrix_id;
  logic [15:0]     rq_rows;
  logic [15:0]     rq_cols;
  logic [2*DW-1:0] rq_data;
  logic [1:0]      rq_data_valid;
  logic [1:0]      rq_grant;
  logic [1:0]      rq_done;
  logic [1:0]      rq_error;
  logic            write_request;
  logic            write_ready;
  logic [2:0]      write_matrix_id;
  logic [7:0]      write_rows;
  logic [7:0]      write_cols;
  logic [DW-1:0]   write_data;
  logic            write_data_valid;
  logic            write_done;
  logic            busy;
  logic            overflow;

  always #5 clk = ~clk;

  matrix_write_arbiter #(.DATA_WIDTH(DW), .MAX_ELEMS(1150)) dut (
    .clk(clk), .rst(rst),
    .rq_request(rq_request), .rq_matrix_id(rq_matrix_id),
    .rq_rows(rq_rows), .rq_cols(rq_cols),
    .rq_data(rq_data), .rq_data_valid(rq_data_valid),
    .rq_grant(rq_grant), .rq_done(rq_done), .rq_error(rq_error),
    .write_request(write_request), .write_ready(write_ready),
    .write_matrix_id(write_matrix_id), .write_rows(write_rows), .write_cols(write_cols),
    .write_data(write_data), .write_data_valid(write_data_valid),
    .write_done(write_done), .busy(busy), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit owner;
    bit err;
    int wreq;
    bit rej;
  } done_t;

  bit          q_owner[$];
  logic [18:0] q_hdr[$];
  logic [31:0] q_data[$];
  done_t       q_done[$];
  int          ovf_exp = 0;
  int          ovf_seen = 0;

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         wreq_cnt = 0;
  int         grant_cyc = 0;
  logic [1:0] prev_grant = 2'b00;
  done_t      mon_d;
  bit         mon_o;

  always @(negedge clk) begin
    cyc++;
    if (rst) wreq_cnt = 0;
    else if (write_request) wreq_cnt++;

    if (rq_grant != 2'b00 && prev_grant == 2'b00) begin
      grant_cyc = cyc;
      if (q_owner.size() == 0) check_eq("grant_unexpected", rq_grant, 0);
      else begin
        mon_o = q_owner.pop_front();
        check_eq("grant_owner", rq_grant, mon_o ? 2'b10 : 2'b01);
      end
    end
    prev_grant = rq_grant;

    if (write_request && write_ready) begin
      if (q_hdr.size() == 0) check_eq("hdr_unexpected", 1, 0);
      else check_eq("header", {write_matrix_id, write_rows, write_cols}, q_hdr.pop_front());
    end

    if (write_data_valid) begin
      if (q_data.size() == 0) check_eq("data_unexpected", write_data, 0);
      else check_eq("write_data", write_data, q_data.pop_front());
    end

    if (overflow) ovf_seen++;

    if (rq_done != 2'b00) begin
      if (q_done.size() == 0) check_eq("done_unexpected", rq_done, 0);
      else begin
        mon_d = q_done.pop_front();
        check_eq("rq_done", rq_done, mon_d.owner ? 2'b10 : 2'b01);
        check_eq("rq_error", rq_error, mon_d.err ? (mon_d.owner ? 2'b10 : 2'b01) : 2'b00);
        check_eq("wreq_cycles", wreq_cnt, mon_d.wreq);
        if (mon_d.rej) check_eq("reject_latency", cyc - grant_cyc, 1);
      end
      wreq_cnt = 0;
    end else if (rq_error != 2'b00) begin
      check_eq("error_without_done", rq_error, 0);
    end
  end

  // ---------------- driver / reference model ----------------
  int cfg_id[2], cfg_rows[2], cfg_cols[2], cfg_beats[2], cfg_rdly[2], cfg_ddly[2];
  bit model_last = 1'b1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic set_hdr(input int i, input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
    rq_matrix_id[i*3 +: 3] = id;
    rq_rows[i*8 +: 8]      = r;
    rq_cols[i*8 +: 8]      = c;
  endtask

  task automatic set_cfg(input int i, input int id, input int r, input int c,
                         input int beats, input int rdly, input int ddly);
    cfg_id[i] = id; cfg_rows[i] = r; cfg_cols[i] = c;
    cfg_beats[i] = beats; cfg_rdly[i] = rdly; cfg_ddly[i] = ddly;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, rq_grant, 0);
    check_eq({tag, "_done"}, rq_done, 0);
    check_eq({tag, "_error"}, rq_error, 0);
    check_eq({tag, "_wreq"}, write_request, 0);
    check_eq({tag, "_wvalid"}, write_data_valid, 0);
    check_eq({tag, "_wdata"}, write_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_header"}, {write_matrix_id, write_rows, write_cols}, 0);
  endtask

  // Runs every requester in mask to completion; abort_at >= 0 resets the DUT after that many beats
  task automatic run_set(input logic [1:0] mask, input int abort_at);
    logic [1:0]  pending;
    bit          exp_owner, own, got, rej;
    int          exp_cnt, fwd;
    logic [31:0] dat;
    done_t       d;
    pending = mask;
    while (pending != 2'b00) begin
      for (int i = 0; i < 2; i++)
        if (pending[i]) set_hdr(i, 3'(cfg_id[i]), 8'(cfg_rows[i]), 8'(cfg_cols[i]));
      rq_request = pending;
      exp_owner = (pending == 2'b11) ? ~model_last : pending[1];
      q_owner.push_back(exp_owner);

      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step(1);
        if (rq_grant != 2'b00) got = 1'b1;
      end
      if (!got) begin
        check_eq("grant_timeout", 0, 1);
        finish_test();
      end
      own = rq_grant[1];
      pending[own] = 1'b0;
      rq_request = pending;
      set_hdr(int'(own), 3'($urandom), 8'($urandom), 8'($urandom));

      exp_cnt = cfg_rows[exp_owner] * cfg_cols[exp_owner];
      rej = (exp_cnt == 0) || (exp_cnt > 1150);
      if (rej) begin
        d = '{exp_owner, 1'b1, 0, 1'b1};
        q_done.push_back(d);
      end else begin
        fwd = (cfg_beats[exp_owner] < exp_cnt) ? cfg_beats[exp_owner] : exp_cnt;
        ovf_exp += cfg_beats[exp_owner] - fwd;
        q_hdr.push_back({3'(cfg_id[exp_owner]), 8'(cfg_rows[exp_owner]), 8'(cfg_cols[exp_owner])});
        d = '{exp_owner, (fwd < exp_cnt), cfg_rdly[exp_owner] + 1, 1'b0};
        q_done.push_back(d);

        for (int c = 0; c < 10 && !write_request; c++) step(1);
        if (!write_request) begin
          check_eq("wreq_timeout", 0, 1);
          finish_test();
        end
        // a write_done while still waiting for the writer must be ignored
        for (int k = 0; k < cfg_rdly[own]; k++) begin
          write_done = (k == 0);
          step(1);
        end
        write_done  = 1'b0;
        write_ready = 1'b1;
        step(1);
        write_ready = 1'b0;

        for (int b = 0; b < cfg_beats[own]; b++) begin
          if (abort_at >= 0 && b == abort_at) begin
            rq_data_valid = 2'b00;
            step(1);
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            check_all_zero("abort");
            void'(q_done.pop_back());
            model_last = 1'b1;
            rq_request = 2'b00;
            return;
          end
          rq_data_valid = 2'b00;
          step($urandom_range(0, 1));
          dat = $urandom;
          if (b < exp_cnt) q_data.push_back(dat);
          rq_data[own*DW +: DW]    = dat;
          rq_data_valid[own]       = 1'b1;
          rq_data[(!own)*DW +: DW] = $urandom;
          rq_data_valid[!own]      = 1'($urandom);
          step(1);
        end
        rq_data_valid = 2'b00;
        step(1 + cfg_ddly[own]);
        write_done = 1'b1;
        step(1);
        write_done = 1'b0;
      end

      for (int c = 0; c < 10 && busy; c++) step(1);
      check_eq("busy_idle", busy, 0);
      model_last = exp_owner;
    end
  endtask

  initial begin
    rst = 1'b1;
    rq_request = '0; rq_matrix_id = '0; rq_rows = '0; rq_cols = '0;
    rq_data = '0; rq_data_valid = '0; write_ready = 1'b0; write_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    // single requester 2x2, long writer latency
    set_cfg(0, 1, 2, 2, 4, 0, 50);
    run_set(2'b01, -1);

    // simultaneous requests alternate
    set_cfg(0, 2, 1, 3, 3, 1, 2);
    set_cfg(1, 5, 2, 1, 2, 0, 1);
    run_set(2'b11, -1);
    set_cfg(0, 3, 2, 2, 4, 0, 0);
    set_cfg(1, 4, 1, 1, 1, 2, 0);
    run_set(2'b11, -1);

    // rejected headers
    set_cfg(1, 6, 0, 7, 0, 0, 0);
    run_set(2'b10, -1);
    set_cfg(1, 7, 40, 40, 0, 0, 0);
    run_set(2'b10, -1);

    // overflow and underrun
    set_cfg(0, 1, 2, 2, 6, 0, 0);
    run_set(2'b01, -1);
    set_cfg(0, 1, 2, 2, 3, 0, 0);
    run_set(2'b01, -1);

    // long writer stall
    set_cfg(1, 2, 3, 2, 6, 20, 0);
    run_set(2'b10, -1);

    // capacity boundary: 1150 fits, 1152 does not
    set_cfg(0, 0, 25, 46, 1150, 0, 0);
    run_set(2'b01, -1);
    set_cfg(0, 0, 24, 48, 0, 0, 0);
    run_set(2'b01, -1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++) begin
        int kind, r, c, e;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin r = 0; c = $urandom_range(0, 5); end
        else if (kind == 1) begin r = 40; c = 40; end
        else begin r = $urandom_range(1, 5); c = $urandom_range(1, 5); end
        e = r * c + $urandom_range(0, 4) - 2;
        if (e < 0) e = 0;
        set_cfg(i, $urandom_range(0, 7), r, c, e, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run_set(2'($urandom_range(1, 3)), -1);
    end

    // reset during STREAM, then tie-break must restart with requester 0
    set_cfg(1, 3, 3, 3, 9, 0, 0);
    run_set(2'b10, 2);
    step(5);
    set_cfg(0, 1, 1, 2, 2, 0, 0);
    set_cfg(1, 2, 2, 1, 2, 0, 0);
    run_set(2'b11, -1);

    step(5);
    check_eq("overflow_count", ovf_seen, ovf_exp);
    check_eq("owner_queue_empty", q_owner.size(), 0);
    check_eq("hdr_queue_empty", q_hdr.size(), 0);
    check_eq("data_queue_empty", q_data.size(), 0);
    check_eq("done_queue_empty", q_done.size(), 0);
    finish_test();
  end

endmodule
